// File: rtl/lifo_cmd_driver.sv
// rtl/lifo_cmd_driver.sv - request/response front end issuing registered push/pop commands to a stack
module lifo_cmd_driver #(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_ENTRIES  = 8,
    parameter int OPCODE_WIDTH = 2,
    parameter int COUNT_WIDTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [OPCODE_WIDTH-1:0]            req_op,
    input  logic [DATA_WIDTH-1:0]              req_data,
    output logic                               rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic                               rsp_err,
    output logic                               rsp_last,
    output logic [OPCODE_WIDTH+DATA_WIDTH-1:0] lifo_vector,
    input  logic [DATA_WIDTH-1:0]              lifo_data,
    output logic [COUNT_WIDTH-1:0]             count
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        WAIT,
        ERR
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_POP   = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUSH  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_FLUSH = OPCODE_WIDTH'(3);

    localparam logic [COUNT_WIDTH-1:0] FULL  = COUNT_WIDTH'(NUM_ENTRIES);
    localparam logic [COUNT_WIDTH-1:0] EMPTY = '0;
    localparam logic [COUNT_WIDTH-1:0] ONE   = COUNT_WIDTH'(1);

    localparam logic [OPCODE_WIDTH+DATA_WIDTH-1:0] VEC_NOP = '0;
    localparam logic [OPCODE_WIDTH+DATA_WIDTH-1:0] VEC_POP = {OP_POP, {DATA_WIDTH{1'b0}}};

    state_t                              state, state_nxt;
    logic [COUNT_WIDTH-1:0]              count_nxt;
    logic                                flush, flush_nxt;
    logic [OPCODE_WIDTH+DATA_WIDTH-1:0]  vector_nxt;
    logic                                rsp_valid_nxt;
    logic                                rsp_err_nxt;
    logic                                rsp_last_nxt;
    logic [DATA_WIDTH-1:0]               rsp_data_nxt;

    // Requests are only taken while idle; every operation returns here.
    assign req_ready = (state == IDLE);

    // State, occupancy, stack command and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            flush       <= 1'b0;
            lifo_vector <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_last    <= 1'b0;
            rsp_data    <= '0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            flush       <= flush_nxt;
            lifo_vector <= vector_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_last    <= rsp_last_nxt;
            rsp_data    <= rsp_data_nxt;
        end
    end

    // Next-state logic; the command and response are computed one cycle
    // ahead so they appear registered in the state they belong to.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        flush_nxt     = flush;
        vector_nxt    = VEC_NOP;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_last_nxt  = 1'b0;
        rsp_data_nxt  = rsp_data;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_PUSH: begin
                            if (count < FULL) begin
                                state_nxt  = PUSH;
                                vector_nxt = {OP_PUSH, req_data};
                                count_nxt  = count + ONE;
                            end else begin
                                state_nxt     = ERR;
                                rsp_valid_nxt = 1'b1;
                                rsp_err_nxt   = 1'b1;
                                rsp_data_nxt  = '0;
                            end
                        end
                        OP_POP, OP_FLUSH: begin
                            if (count != EMPTY) begin
                                state_nxt  = POP;
                                vector_nxt = VEC_POP;
                                flush_nxt  = (req_op == OP_FLUSH);
                            end else begin
                                // Empty flush reports as a single, final error.
                                state_nxt     = ERR;
                                rsp_valid_nxt = 1'b1;
                                rsp_err_nxt   = 1'b1;
                                rsp_last_nxt  = (req_op == OP_FLUSH);
                                rsp_data_nxt  = '0;
                            end
                        end
                        default: begin
                            state_nxt = IDLE;
                        end
                    endcase
                end
            end
            PUSH: begin
                state_nxt = IDLE;
            end
            POP: begin
                state_nxt = WAIT;
                count_nxt = (count != EMPTY) ? count - ONE : EMPTY;
            end
            WAIT: begin
                // Stack output now reflects the pop issued during POP.
                rsp_valid_nxt = 1'b1;
                rsp_data_nxt  = lifo_data;
                rsp_last_nxt  = flush && (count == EMPTY);
                if (flush && (count != EMPTY)) begin
                    state_nxt  = POP;
                    vector_nxt = VEC_POP;
                end else begin
                    state_nxt = IDLE;
                    flush_nxt = 1'b0;
                end
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                flush_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lifo_cmd_driver.sv
// tb/tb_lifo_cmd_driver.sv - directed scoreboard bench for lifo_cmd_driver
module tb_lifo_cmd_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_data = 4'h0;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic       rsp_last;
    logic [5:0] lifo_vector;
    logic [3:0] lifo_data;
    logic [3:0] count;

    lifo_cmd_driver #(
        .DATA_WIDTH(4),
        .NUM_ENTRIES(8),
        .OPCODE_WIDTH(2),
        .COUNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_data(req_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .rsp_last(rsp_last),
        .lifo_vector(lifo_vector),
        .lifo_data(lifo_data),
        .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stack with a registered data output, sharing the reset.
    logic [3:0] mem [0:7];
    int         sp = 0;
    always @(posedge clk) begin
        if (reset) begin
            sp        <= 0;
            lifo_data <= 4'h0;
        end else if (lifo_vector[5:4] == 2'b10) begin
            mem[sp[2:0]] <= lifo_vector[3:0];
            sp           <= sp + 1;
        end else if (lifo_vector[5:4] == 2'b01) begin
            lifo_data <= mem[(sp - 1) & 7];
            sp        <= sp - 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [3:0] data;
        logic       err;
        logic       last;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [3:0] last_data = 4'h0;

    // Response monitor: pops the scoreboard on each strobe, polices idle outputs.
    always @(negedge clk) begin
        if (reset) begin
            last_data = rsp_data;
        end else begin
            check("vec_op_not_11", {31'd0, lifo_vector[5:4] == 2'b11}, 32'd0);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {28'd0, rsp_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", {28'd0, rsp_data}, {28'd0, e.data});
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    check("rsp_last", {31'd0, rsp_last}, {31'd0, e.last});
                    check("rsp_cycle", cyc, e.cyc);
                end
                last_data = rsp_data;
            end else begin
                check("idle_err_low", {31'd0, rsp_err}, 32'd0);
                check("idle_last_low", {31'd0, rsp_last}, 32'd0);
                check("rsp_data_hold", {28'd0, rsp_data}, {28'd0, last_data});
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] d, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_bound", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = 4'($urandom);
    endtask

    task automatic push_ok(input logic [3:0] d);
        int acc;
        send(2'b10, d, acc);
        @(negedge clk);
        check("push_vector", {26'd0, lifo_vector}, {26'd0, 2'b10, d});
        @(negedge clk);
        check("push_then_nop", {26'd0, lifo_vector}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    int acc;

    initial begin
        // Reset values and first cycle after reset.
        do_reset();
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_count", {28'd0, count}, 32'd0);
        check("reset_vector", {26'd0, lifo_vector}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", {28'd0, rsp_data}, 32'd0);

        // Three pushes, then a pop of the top entry.
        push_ok(4'h3);
        push_ok(4'h5);
        push_ok(4'h9);
        check("count_after_3_push", {28'd0, count}, 32'd3);
        send(2'b01, 4'h0, acc);
        sb.push_back('{data: 4'h9, err: 1'b0, last: 1'b0, cyc: acc + 2});
        @(negedge clk);
        check("pop_vector", {26'd0, lifo_vector}, 32'h10);
        drain();
        check("count_after_pop", {28'd0, count}, 32'd2);

        // Opcode 00 is accepted silently.
        send(2'b00, 4'h7, acc);
        @(negedge clk);
        check("nop_vector", {26'd0, lifo_vector}, 32'd0);
        repeat (4) @(negedge clk);
        check("nop_count", {28'd0, count}, 32'd2);

        // Pop on empty.
        do_reset();
        send(2'b01, 4'h0, acc);
        sb.push_back('{data: 4'h0, err: 1'b1, last: 1'b0, cyc: acc});
        @(negedge clk);
        check("underflow_vector", {26'd0, lifo_vector}, 32'd0);
        drain();
        check("underflow_count", {28'd0, count}, 32'd0);

        // Fill to depth, then overflow.
        do_reset();
        for (int i = 0; i < 8; i++) push_ok(4'(i + 1));
        check("count_full", {28'd0, count}, 32'd8);
        send(2'b10, 4'hF, acc);
        sb.push_back('{data: 4'h0, err: 1'b1, last: 1'b0, cyc: acc});
        @(negedge clk);
        check("overflow_vector", {26'd0, lifo_vector}, 32'd0);
        drain();
        check("overflow_count", {28'd0, count}, 32'd8);

        // Flush of three entries.
        do_reset();
        push_ok(4'h1);
        push_ok(4'h2);
        push_ok(4'h3);
        send(2'b11, 4'h0, acc);
        sb.push_back('{data: 4'h3, err: 1'b0, last: 1'b0, cyc: acc + 2});
        sb.push_back('{data: 4'h2, err: 1'b0, last: 1'b0, cyc: acc + 4});
        sb.push_back('{data: 4'h1, err: 1'b0, last: 1'b1, cyc: acc + 6});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_ready_low", {31'd0, req_ready}, 32'd0);
        end
        drain();
        check("flush_count", {28'd0, count}, 32'd0);
        check("flush_ready_after", {31'd0, req_ready}, 32'd1);

        // Reset while the flush sits in WAIT: nothing further may come out.
        do_reset();
        push_ok(4'h1);
        push_ok(4'h2);
        push_ok(4'h3);
        send(2'b11, 4'h0, acc);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midflush_ready", {31'd0, req_ready}, 32'd1);
        check("midflush_count", {28'd0, count}, 32'd0);
        check("midflush_vector", {26'd0, lifo_vector}, 32'd0);
        check("midflush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (8) @(negedge clk);

        // Flush on empty.
        send(2'b11, 4'h0, acc);
        sb.push_back('{data: 4'h0, err: 1'b1, last: 1'b1, cyc: acc});
        drain();
        check("empty_flush_count", {28'd0, count}, 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
